// File: rtl/rf_channel_capture_pkg.sv
// Shared beamformer definitions: default frame geometry and the capture write-FSM encoding.
package rf_channel_capture_pkg;

  localparam int unsigned CHANNELS_DEF = 128;
  localparam int unsigned IDX_W_DEF    = 8;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned COUNT_W      = 16;

  typedef enum logic [1:0] {
    WR_IDLE      = 2'd0,
    WR_FILL      = 2'd1,
    WR_WAIT_BANK = 2'd2
  } wr_state_e;

endpackage

// File: rtl/rf_channel_capture_if.sv
// Sample stream, frame readout and status bundle between the RF front end and the capture block.
interface rf_channel_capture_if
  import rf_channel_capture_pkg::*;
#(
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic                     in_valid;
  logic                     in_sof;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     frame_valid;
  logic [IDX_W-1:0]         rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     frame_release;
  logic                     overflow;
  logic                     short_frame;
  logic [COUNT_W-1:0]       frame_count;

  modport master (
    output in_valid, in_sof, in_data, rd_addr, frame_release,
    input  in_ready, frame_valid, rd_data, overflow, short_frame, frame_count
  );

  modport slave (
    input  in_valid, in_sof, in_data, rd_addr, frame_release,
    output in_ready, frame_valid, rd_data, overflow, short_frame, frame_count
  );

endinterface

// File: rtl/rf_bank_ram.sv
// One capture bank: single write port, single registered read port, no reset so it maps to block RAM.
module rf_bank_ram #(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  // Out-of-range addresses are dropped on write and leave the read register unchanged.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
    if (32'(raddr) < DEPTH) begin
      rdata <= mem[raddr[AW-1:0]];
    end
  end

endmodule

// File: rtl/rf_channel_capture.sv
// Ping-pong frame capture: descending-order channel stream into two banks, random-access readout of the read bank.
module rf_channel_capture
  import rf_channel_capture_pkg::*;
#(
  parameter int unsigned CHANNELS = CHANNELS_DEF,
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_channel_capture_if.slave  bus
);

  localparam logic [IDX_W-1:0] TOP_ADDR = IDX_W'(CHANNELS - 1);

  wr_state_e          state_q, state_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [1:0]         full_q, full_d;
  logic [IDX_W-1:0]   wr_addr_q, wr_addr_d;
  logic               overflow_q, overflow_d;
  logic               short_q, short_d;
  logic               frame_valid_q, frame_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [COUNT_W-1:0] count_q;
  logic               rd_sel_q;
  logic               rd_live_q;

  logic               accept_c;
  logic               release_c;
  logic               other_free_c;
  logic               wr_en_c;
  logic               complete_c;
  logic [IDX_W-1:0]   wa_c;

  logic [DATA_W-1:0]  q0, q1;

  // Write FSM, bank flags and pointers; release and completion are resolved in one pass.
  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    full_d        = full_q;
    wr_addr_d     = wr_addr_q;
    overflow_d    = overflow_q;
    short_d       = short_q;
    wr_en_c       = 1'b0;
    complete_c    = 1'b0;
    wa_c          = wr_addr_q;

    accept_c  = bus.in_valid && in_ready_q;
    release_c = bus.frame_release && frame_valid_q;
    // The other bank counts as free if it is empty or is being released this cycle.
    other_free_c = !full_q[!wr_bank_q] || (release_c && (rd_bank_q != wr_bank_q));

    if (bus.in_valid && !in_ready_q) begin
      overflow_d = 1'b1;
    end

    if (release_c) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end

    unique case (state_q)
      WR_IDLE: begin
        if (accept_c && bus.in_sof) begin
          wr_en_c = 1'b1;
          wa_c    = TOP_ADDR;
          state_d = WR_FILL;
        end
      end
      WR_FILL: begin
        if (accept_c) begin
          wr_en_c = 1'b1;
          if (bus.in_sof) begin
            wa_c = TOP_ADDR;
            if (wr_addr_q != TOP_ADDR) begin
              short_d = 1'b1;
            end
          end
        end
      end
      WR_WAIT_BANK: begin
        if (other_free_c) begin
          state_d   = WR_IDLE;
          wr_bank_d = !wr_bank_q;
        end
      end
      default: state_d = WR_IDLE;
    endcase

    if (wr_en_c) begin
      if (wa_c == '0) begin
        complete_c        = 1'b1;
        full_d[wr_bank_q] = 1'b1;
        wr_addr_d         = TOP_ADDR;
        if (other_free_c) begin
          wr_bank_d = !wr_bank_q;
          state_d   = WR_IDLE;
        end else begin
          state_d   = WR_WAIT_BANK;
        end
      end else begin
        wr_addr_d = wa_c - IDX_W'(1);
      end
    end

    frame_valid_d = full_d[rd_bank_d];
    in_ready_d    = (state_d != WR_WAIT_BANK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WR_IDLE;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      full_q        <= 2'b00;
      wr_addr_q     <= TOP_ADDR;
      overflow_q    <= 1'b0;
      short_q       <= 1'b0;
      frame_valid_q <= 1'b0;
      in_ready_q    <= 1'b0;
      count_q       <= '0;
      rd_sel_q      <= 1'b0;
      rd_live_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      full_q        <= full_d;
      wr_addr_q     <= wr_addr_d;
      overflow_q    <= overflow_d;
      short_q       <= short_d;
      frame_valid_q <= frame_valid_d;
      in_ready_q    <= in_ready_d;
      rd_sel_q      <= rd_bank_q;
      rd_live_q     <= 1'b1;
      if (complete_c) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  rf_bank_ram #(
    .DEPTH  (CHANNELS),
    .ADDR_W (IDX_W),
    .DATA_W (DATA_W)
  ) u_bank0 (
    .clk   (clk),
    .we    (wr_en_c && !wr_bank_q),
    .waddr (wa_c),
    .wdata (bus.in_data),
    .raddr (bus.rd_addr),
    .rdata (q0)
  );

  rf_bank_ram #(
    .DEPTH  (CHANNELS),
    .ADDR_W (IDX_W),
    .DATA_W (DATA_W)
  ) u_bank1 (
    .clk   (clk),
    .we    (wr_en_c && wr_bank_q),
    .waddr (wa_c),
    .wdata (bus.in_data),
    .raddr (bus.rd_addr),
    .rdata (q1)
  );

  // Read data is held at zero until the first read after reset has been registered.
  assign bus.rd_data     = rd_live_q ? (rd_sel_q ? q1 : q0) : '0;
  assign bus.in_ready    = in_ready_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.overflow    = overflow_q;
  assign bus.short_frame = short_q;
  assign bus.frame_count = count_q;

endmodule

// File: tb/tb_rf_channel_capture.sv
// Directed bench for rf_channel_capture: ping-pong capture, overflow, short frame, release races, reset, count wrap.
module tb_rf_channel_capture;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  bit   rdy_low;

  rf_channel_capture_if #(.IDX_W(8), .DATA_W(16)) bus ();

  rf_channel_capture #(
    .CHANNELS (128),
    .IDX_W    (8),
    .DATA_W   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Streams n descending values starting at first_val; in_sof on the first beat when sof is set.
  task automatic beats(input int first_val, input int n, input bit sof);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sof   = sof && (i == 0);
      bus.in_data  = 16'(first_val - i);
      if (bus.in_ready !== 1'b1) rdy_low = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int addr, input int exp);
    bus.rd_addr = 8'(addr);
    @(negedge clk);
    chk(tag, 16'(bus.rd_data), 16'(exp));
  endtask

  task automatic release_pulse();
    bus.frame_release = 1'b1;
    @(negedge clk);
    bus.frame_release = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rdy_low = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_data = '0;
    bus.rd_addr = '0;
    bus.frame_release = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
    chk("rst_frame_valid", 16'(bus.frame_valid), 16'd0);
    chk("rst_frame_count", bus.frame_count, 16'd0);
    chk("rst_rd_data", 16'(bus.rd_data), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 16'(bus.in_ready), 16'd1);

    // Single frame, data 127..0 lands at addresses 127..0.
    beats(127, 127, 1'b1);
    chk("f1_valid_before_last", 16'(bus.frame_valid), 16'd0);
    beats(0, 1, 1'b0);
    chk("f1_valid_after_last", 16'(bus.frame_valid), 16'd1);
    chk("f1_count", bus.frame_count, 16'd1);
    chk("f1_ready", 16'(bus.in_ready), 16'd1);
    rd_chk("f1_rd0", 0, 0);
    rd_chk("f1_rd64", 64, 64);
    rd_chk("f1_rd127", 127, 127);
    release_pulse();
    chk("f1_released", 16'(bus.frame_valid), 16'd0);

    // Two back-to-back frames, no release, then a third sof while both banks are full.
    rdy_low = 1'b0;
    beats(1127, 128, 1'b1);
    beats(2127, 128, 1'b1);
    chk("b2b_ready_held", 16'(rdy_low), 16'd0);
    chk("b2b_count", bus.frame_count, 16'd3);
    chk("b2b_ready_low", 16'(bus.in_ready), 16'd0);
    chk("b2b_valid", 16'(bus.frame_valid), 16'd1);
    rd_chk("b2b_rdA", 10, 1010);
    chk("b2b_no_ovf_yet", 16'(bus.overflow), 16'd0);
    beats(9000, 1, 1'b1);
    chk("b2b_overflow", 16'(bus.overflow), 16'd1);
    chk("b2b_dropped", bus.frame_count, 16'd3);
    release_pulse();
    chk("b2b_next_valid", 16'(bus.frame_valid), 16'd1);
    chk("b2b_ready_back", 16'(bus.in_ready), 16'd1);
    rd_chk("b2b_rdB", 10, 2010);

    // Release on the same cycle as the last beat of the next frame.
    beats(3127, 127, 1'b1);
    chk("race_valid_before", 16'(bus.frame_valid), 16'd1);
    bus.frame_release = 1'b1;
    beats(3000, 1, 1'b0);
    bus.frame_release = 1'b0;
    chk("race_valid_after", 16'(bus.frame_valid), 16'd1);
    chk("race_count", bus.frame_count, 16'd4);
    chk("race_ready", 16'(bus.in_ready), 16'd1);
    rd_chk("race_rd0", 0, 3000);
    rd_chk("race_rd127", 127, 3127);

    // Reset in the middle of a frame.
    beats(4127, 64, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 16'(bus.in_ready), 16'd0);
    chk("mid_rst_valid", 16'(bus.frame_valid), 16'd0);
    chk("mid_rst_count", bus.frame_count, 16'd0);
    chk("mid_rst_ovf", 16'(bus.overflow), 16'd0);
    chk("mid_rst_rd_data", 16'(bus.rd_data), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 16'(bus.in_ready), 16'd1);

    // Release with no valid frame and stray beats without sof are both ignored.
    release_pulse();
    beats(-5, 3, 1'b0);
    chk("idle_discard_count", bus.frame_count, 16'd0);
    chk("idle_discard_short", 16'(bus.short_frame), 16'd0);
    chk("idle_discard_valid", 16'(bus.frame_valid), 16'd0);

    // Short frame: sof at beat 50, then a complete frame.
    beats(-100, 50, 1'b1);
    chk("short_not_yet", 16'(bus.short_frame), 16'd0);
    beats(5127, 128, 1'b1);
    chk("short_flag", 16'(bus.short_frame), 16'd1);
    chk("short_count", bus.frame_count, 16'd1);
    chk("short_valid", 16'(bus.frame_valid), 16'd1);
    chk("short_no_ovf", 16'(bus.overflow), 16'd0);
    rd_chk("short_rd0", 0, 5000);
    rd_chk("short_rd100", 100, 5100);
    rd_chk("short_rd127", 127, 5127);

    // Frame counter wrap from 65535.
    dut.count_q = 16'hFFFF;
    @(negedge clk);
    beats(6127, 128, 1'b1);
    chk("wrap_count", bus.frame_count, 16'd0);
    chk("wrap_ready_low", 16'(bus.in_ready), 16'd0);
    rd_chk("wrap_rd_old", 3, 5003);
    release_pulse();
    chk("wrap_valid_new", 16'(bus.frame_valid), 16'd1);
    chk("wrap_ready_back", 16'(bus.in_ready), 16'd1);
    rd_chk("wrap_rd_new", 3, 6003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_channel_capture.md
RF_CHANNEL_CAPTURE -- requirements
Module: rf_channel_capture

Interface
REQ-001 The block SHALL expose the following parameters, one per line.
  - CHANNELS, default 128, number of channel samples per frame.
  - IDX_W, default 8, channel index/address width, with 2^IDX_W >= CHANNELS.
  - DATA_W, default 16, signed sample width.
REQ-002 The block SHALL expose the following ports, one per line.
  - clk  in  1  clock.
  - rst  in  1  synchronous, active-high reset.
  - in_valid  in  1  serial sample strobe.
  - in_sof  in  1  first sample of a frame; qualified by in_valid.
  - in_data  in  DATA_W  signed channel sample.
  - in_ready  out  1  block can accept a sample this cycle.
  - frame_valid  out  1  a complete frame is readable.
  - rd_addr  in  IDX_W  channel index to read.
  - rd_data  out  DATA_W  signed sample at rd_addr.
  - frame_release  in  1  consumer is done with the current frame; pulse.
  - overflow  out  1  sticky; a sample was offered while in_ready was low.
  - short_frame  out  1  sticky; in_sof arrived mid-frame.
  - frame_count  out  16  completed frames, wrapping.

Function
REQ-003 A sample SHALL be accepted only on a cycle where in_valid and in_ready are both high.
REQ-004 Storage SHALL be two banks (ping-pong), each holding CHANNELS x DATA_W; each bank SHALL carry a full flag.
REQ-005 Channel ordering SHALL be descending, matching the streaming transmitter.
  - The first sample of a frame is written to address CHANNELS-1.
  - Each subsequent sample is written to the next lower address.
  - The final sample is written to address 0.
REQ-006 The write FSM SHALL have three states: IDLE, FILL and WAIT_BANK.
  - IDLE -> FILL: on an accepted beat with in_sof.
  - FILL -> IDLE: when the address-0 sample is written and the other bank is empty.
  - FILL -> WAIT_BANK: when the address-0 sample is written and the other bank is full.
  - WAIT_BANK -> IDLE: when the other bank is released.
REQ-007 In IDLE, an accepted beat without in_sof SHALL be discarded and SHALL NOT set any flag.
REQ-008 When the address-0 sample is written, the write bank's full flag SHALL be set on the next edge, frame_count SHALL increment, and the write pointer SHALL toggle to the other bank if that bank is empty.
REQ-009 in_ready SHALL be high in IDLE and FILL, and low in WAIT_BANK and during reset.
REQ-010 overflow SHALL be set on any cycle with in_valid=1 and in_ready=0; the offered sample is dropped.
REQ-011 short_frame SHALL be set when an accepted beat has in_sof in FILL with the write address not equal to CHANNELS-1.
  - The partial frame is discarded.
  - The sof sample is written to address CHANNELS-1 and filling restarts.
REQ-012 frame_valid SHALL equal the full flag of the read bank, and SHALL rise on the cycle after the address-0 sample is written when the read bank equals the write bank.
REQ-013 frame_release while frame_valid=1 SHALL clear the read bank's full flag and toggle the read pointer; frame_release while frame_valid=0 SHALL be ignored.
REQ-014 When frame completion and frame_release occur on the same cycle, both SHALL be honoured.
  - If completion targets the bank being released, that bank SHALL end full.
  - Otherwise that bank SHALL end empty.
REQ-015 rd_data SHALL be registered, returning the read-bank content at rd_addr one cycle after rd_addr is presented.
REQ-016 rd_data SHALL be undefined for rd_addr >= CHANNELS or when frame_valid=0.
REQ-017 frame_count SHALL wrap from 65535 to 0.
REQ-018 Worst-case sustained throughput SHALL be one sample per clock, with no bubbles between frames while a bank is free.

Reset
REQ-019 On rst, the block SHALL:
  - set the FSM to IDLE and both full flags to 0;
  - set the write and read pointers to bank 0 and the write address to CHANNELS-1;
  - clear overflow, short_frame, frame_count, frame_valid and rd_data to 0;
  - drive in_ready low.
REQ-020 in_ready SHALL rise on the first cycle after rst deasserts.
REQ-021 A reset asserted mid-frame or with full banks SHALL discard all frames; bank memory contents need not be cleared.

Structure
REQ-022 The default CHANNELS, IDX_W and DATA_W values and the write-FSM state encoding SHALL live in the shared beamformer package.
REQ-023 Each bank SHALL be a sub-module, rf_bank_ram: a single-write, single-registered-read port RAM, inferred as block RAM, instantiated twice.

Verification
REQ-024 The bench SHALL cover the following directed scenarios.
  - Stream one 128-sample frame with in_sof on the first beat and data = 127..0 -> frame_valid rises 1 cycle after the last beat; rd_addr=k returns k one cycle later; frame_count=1.
  - Stream two back-to-back frames with no release -> in_ready stays high throughout, both banks end full; a third in_sof is offered -> in_ready=0, overflow=1, sample dropped.
  - Send in_sof at beat 50, then a full 128-sample frame -> short_frame=1; the second frame reads back intact; frame_count=1.
  - Assert frame_release on the same cycle as the last beat of frame 2 while frame 1 is valid -> frame 2 becomes valid the next cycle; frame_valid stays 1.
  - Assert rst at beat 64 of a frame -> in_ready=0 during rst, frame_valid=0, flags and frame_count cleared; a fresh frame after reset captures correctly.
  - Preload frame_count to 65535 and complete a frame -> frame_count=0.
